// File: rtl/dfp128_unpack_if.sv
// Handshake bundle between a decimal128 producer, the unpacker and its consumer.
// The slave side is the unpacker; the master side is whoever feeds and drains it.
interface dfp128_unpack_if #(
  parameter int N = 34
);
  logic                 i_valid;
  logic                 i_ready;
  logic [127:0]         i;
  logic                 o_valid;
  logic                 o_ready;
  logic                 o_sign;
  logic [13:0]          o_exp;
  logic [(N+1)*4-1:0]   o_sig;
  logic                 o_nan;
  logic                 o_qnan;
  logic                 o_snan;
  logic                 o_inf;
  logic                 o_zero;

  modport master (
    output i_valid, i, o_ready,
    input  i_ready, o_valid, o_sign, o_exp, o_sig,
           o_nan, o_qnan, o_snan, o_inf, o_zero
  );

  modport slave (
    input  i_valid, i, o_ready,
    output i_ready, o_valid, o_sign, o_exp, o_sig,
           o_nan, o_qnan, o_snan, o_inf, o_zero
  );
endinterface

// File: rtl/dfp128_unpack.sv
// Sequential decimal128 (DPD) unpacker.
// Decodes the combination field on acceptance, then one declet per cycle
// (most significant first) through a single shared DPD-to-BCD decoder,
// then optionally left-normalizes one digit per cycle. The result, with a
// trailing zero round digit, is presented with valid/ready until taken.
module dfp128_unpack #(
  parameter int N    = 34,
  parameter bit NORM = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  dfp128_unpack_if.slave bus
);

  localparam int SW = N * 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_NORM,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers for the operand in flight.
  logic [109:0]  declets;
  logic [3:0]    cnt;
  logic [SW-1:0] sig;
  logic [13:0]   work_exp;
  logic          sign;
  logic          is_inf;
  logic          is_nan;
  logic          is_snan;

  // Output registers; they only change on the edge that enters DONE.
  logic [SW-1:0] out_sig;
  logic [13:0]   out_exp;
  logic          out_sign;
  logic          out_nan;
  logic          out_qnan;
  logic          out_snan;
  logic          out_inf;
  logic          out_zero;

  // Combination-field decode of the word currently on the input bus.
  logic [4:0]    g;
  logic [13:0]   in_exp;
  logic [3:0]    in_msd;
  logic          in_inf;
  logic          in_nan;

  // Shared declet decoder.
  logic [9:0]    dpd;
  logic [11:0]   bcd;

  logic          accept;
  logic          shift_ok;

  assign g       = bus.i[126:122];
  assign accept  = bus.i_valid && (state == S_IDLE);
  assign dpd     = declets[109:100];

  // Split the combination field into exponent MSBs, leading digit and specials.
  always_comb begin
    in_exp = {g[4:3], bus.i[121:110]};
    in_msd = {1'b0, g[2:0]};
    in_inf = 1'b0;
    in_nan = 1'b0;
    if (g[4:3] == 2'b11) begin
      if (g[2:1] != 2'b11) begin
        in_exp = {g[2:1], bus.i[121:110]};
        in_msd = {3'b100, g[0]};
      end else begin
        in_exp = 14'h3FFF;
        in_msd = 4'h0;
        in_inf = ~g[0];
        in_nan = g[0];
      end
    end
  end

  // DPD declet to three BCD digits; bits are p q r s t u v w x y from 9 down to 0.
  // Non-canonical patterns fall into the wx=11/st=11 arm and ignore p and q.
  always_comb begin
    bcd = {1'b0, dpd[9:7], 1'b0, dpd[6:4], 1'b0, dpd[2:0]};
    if (dpd[3]) begin
      case (dpd[2:1])
        2'b00:   bcd = {1'b0, dpd[9:7], 1'b0, dpd[6:4], 3'b100, dpd[0]};
        2'b01:   bcd = {1'b0, dpd[9:7], 3'b100, dpd[4], 1'b0, dpd[6:5], dpd[0]};
        2'b10:   bcd = {3'b100, dpd[7], 1'b0, dpd[6:4], 1'b0, dpd[9:8], dpd[0]};
        default: begin
          if (dpd[6:5] == 2'b00)
            bcd = {3'b100, dpd[7], 3'b100, dpd[4], 1'b0, dpd[9:8], dpd[0]};
          else if (dpd[6:5] == 2'b01)
            bcd = {3'b100, dpd[7], 1'b0, dpd[9:8], dpd[4], 3'b100, dpd[0]};
          else if (dpd[6:5] == 2'b10)
            bcd = {1'b0, dpd[9:7], 3'b100, dpd[4], 3'b100, dpd[0]};
          else
            bcd = {3'b100, dpd[7], 3'b100, dpd[4], 3'b100, dpd[0]};
        end
      endcase
    end
  end

  // A normalizing shift is only worthwhile for a finite, nonzero value whose
  // leading digit is zero and whose exponent still has room to drop.
  assign shift_ok = NORM && !is_inf && !is_nan && (sig != '0) &&
                    (sig[SW-1 -: 4] == 4'h0) && (work_exp != 14'd0);

  // Next-state selection for the IDLE -> DECODE -> NORM -> DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.i_valid)   state_next = S_DECODE;
      S_DECODE: if (cnt == 4'd10)  state_next = S_NORM;
      S_NORM:   if (!shift_ok)     state_next = S_DONE;
      S_DONE:   if (bus.o_ready)   state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath: capture, declet shifting, normalization and result publishing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      declets  <= '0;
      cnt      <= '0;
      sig      <= '0;
      work_exp <= '0;
      sign     <= 1'b0;
      is_inf   <= 1'b0;
      is_nan   <= 1'b0;
      is_snan  <= 1'b0;
      out_sig  <= '0;
      out_exp  <= '0;
      out_sign <= 1'b0;
      out_nan  <= 1'b0;
      out_qnan <= 1'b0;
      out_snan <= 1'b0;
      out_inf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            declets  <= bus.i[109:0];
            cnt      <= 4'd0;
            sig      <= {{(SW-4){1'b0}}, in_msd};
            work_exp <= in_exp;
            sign     <= bus.i[127];
            is_inf   <= in_inf;
            is_nan   <= in_nan;
            is_snan  <= in_nan & bus.i[121];
          end
        end
        S_DECODE: begin
          sig     <= {sig[SW-13:0], (is_inf ? 12'h000 : bcd)};
          declets <= {declets[99:0], 10'b0};
          cnt     <= cnt + 4'd1;
        end
        S_NORM: begin
          if (shift_ok) begin
            sig      <= {sig[SW-5:0], 4'h0};
            work_exp <= work_exp - 14'd1;
          end else begin
            out_sig  <= sig;
            out_exp  <= work_exp;
            out_sign <= sign;
            out_inf  <= is_inf;
            out_nan  <= is_nan;
            out_snan <= is_snan;
            out_qnan <= is_nan & ~is_snan;
            out_zero <= (sig == '0) && !is_inf && !is_nan;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_ready = (state == S_IDLE);
  assign bus.o_valid = (state == S_DONE);
  assign bus.o_sign  = out_sign;
  assign bus.o_exp   = out_exp;
  assign bus.o_sig   = {out_sig, 4'h0};
  assign bus.o_nan   = out_nan;
  assign bus.o_qnan  = out_qnan;
  assign bus.o_snan  = out_snan;
  assign bus.o_inf   = out_inf;
  assign bus.o_zero  = out_zero;

endmodule

// File: tb/tb_dfp128_unpack.sv
// Scoreboard bench for dfp128_unpack: one normalizing instance and one
// non-normalizing instance. Expected results come from a reference model
// whose DPD decode table is built by inverting a BCD-to-DPD encoder.
module tb_dfp128_unpack;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  typedef struct {
    logic         sign;
    logic [13:0]  ex;
    logic [139:0] sig;
    logic [4:0]   flags;   // {nan, qnan, snan, inf, zero}
    int           lat;
  } res_t;

  res_t sbq[$];
  int   dec_tab[1024];

  localparam logic [127:0] ONE_E0 = 128'h2208_0000_0000_0000_0000_0000_0000_0001;

  dfp128_unpack_if #(.N(34)) ifa ();
  dfp128_unpack_if #(.N(34)) ifb ();

  dfp128_unpack #(.N(34), .NORM(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  dfp128_unpack #(.N(34), .NORM(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Forward BCD -> DPD encoder (hundreds abcd, tens efgh, units ijkm).
  function automatic logic [9:0] dpd_enc(input int v);
    logic [3:0] h, t, u;
    logic [9:0] r;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    case ({h[3], t[3], u[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, u[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, u[0]};
      3'b010:  r = {h[2:0], u[2:1], t[0], 1'b1, 2'b01, u[0]};
      3'b100:  r = {u[2:1], h[0], t[2:0], 1'b1, 2'b10, u[0]};
      3'b110:  r = {u[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, u[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, u[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, u[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, u[0]};
    endcase
    return r;
  endfunction

  function automatic res_t model(input logic [127:0] x, input bit norm);
    res_t r;
    logic [4:0]   g;
    logic [3:0]   msd;
    logic [135:0] s;
    logic         nan, qnan, snan, inf;
    int           v;
    g    = x[126:122];
    nan  = 1'b0; qnan = 1'b0; snan = 1'b0; inf = 1'b0;
    r.sign = x[127];
    if (g[4:3] != 2'b11) begin
      r.ex = {g[4:3], x[121:110]};
      msd  = {1'b0, g[2:0]};
    end else if (g[2:1] != 2'b11) begin
      r.ex = {g[2:1], x[121:110]};
      msd  = {3'b100, g[0]};
    end else begin
      r.ex = 14'h3FFF;
      msd  = 4'h0;
      if (g[0]) begin
        nan  = 1'b1;
        snan = x[121];
        qnan = ~x[121];
      end else begin
        inf = 1'b1;
      end
    end
    s = {132'd0, msd};
    for (int d = 10; d >= 0; d--) begin
      v = dec_tab[x[d*10 +: 10]];
      s = {s[123:0], 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    end
    if (inf) s = '0;
    r.lat = 12;
    if (norm && !inf && !nan) begin
      while (s != '0 && s[135:132] == 4'h0 && r.ex != 14'd0) begin
        s     = {s[131:0], 4'h0};
        r.ex  = r.ex - 14'd1;
        r.lat = r.lat + 1;
      end
    end
    r.sig   = {s, 4'h0};
    r.flags = {nan, qnan, snan, inf, (s == '0) && !inf && !nan};
    return r;
  endfunction

  function automatic res_t sample(input bit b);
    res_t s;
    if (b) begin
      s.sign  = ifb.o_sign;
      s.ex    = ifb.o_exp;
      s.sig   = ifb.o_sig;
      s.flags = {ifb.o_nan, ifb.o_qnan, ifb.o_snan, ifb.o_inf, ifb.o_zero};
    end else begin
      s.sign  = ifa.o_sign;
      s.ex    = ifa.o_exp;
      s.sig   = ifa.o_sig;
      s.flags = {ifa.o_nan, ifa.o_qnan, ifa.o_snan, ifa.o_inf, ifa.o_zero};
    end
    s.lat = 0;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [139:0] act, input logic [139:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic drive(input bit b, input logic v, input logic [127:0] x);
    if (b) begin ifb.i_valid = v; ifb.i = x; end
    else   begin ifa.i_valid = v; ifa.i = x; end
  endtask

  task automatic set_ready(input bit b, input logic r);
    if (b) ifb.o_ready = r;
    else   ifa.o_ready = r;
  endtask

  function automatic logic get_iready(input bit b);
    return b ? ifb.i_ready : ifa.i_ready;
  endfunction

  function automatic logic get_ovalid(input bit b);
    return b ? ifb.o_valid : ifa.o_valid;
  endfunction

  task automatic applyStimulus(input bit b, input logic [127:0] x);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!get_iready(b) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("accept_wait", 140'd0, 140'd1);
    drive(b, 1'b1, x);
    acc_cyc = cyc + 1;
    sbq.push_back(model(x, !b));
    @(negedge clk);
    drive(b, 1'b0, ~x);
  endtask

  task automatic checkResult(input bit b, input int hold, input bit with_next, input logic [127:0] nxt);
    res_t e, o, o0;
    int   guard;
    guard = 0;
    while (!get_ovalid(b) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 140'd0, 140'd1);
      return;
    end
    e = sbq.pop_front();
    if (!get_ovalid(b)) begin
      checkOutput("done_wait", 140'd0, 140'd1);
      return;
    end
    o0 = sample(b);
    checkOutput("latency", 140'(cyc - acc_cyc), 140'(e.lat));
    checkOutput("sign", 140'(o0.sign), 140'(e.sign));
    checkOutput("exp", 140'(o0.ex), 140'(e.ex));
    checkOutput("sig", o0.sig, e.sig);
    checkOutput("flags", 140'(o0.flags), 140'(e.flags));
    if (with_next) drive(b, 1'b1, nxt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      o = sample(b);
      checkOutput("hold_sig", o.sig, o0.sig);
      checkOutput("hold_fields", 140'({o.sign, o.ex, o.flags}), 140'({o0.sign, o0.ex, o0.flags}));
      checkOutput("hold_ovalid", 140'(get_ovalid(b)), 140'd1);
      checkOutput("hold_iready", 140'(get_iready(b)), 140'd0);
    end
    set_ready(b, 1'b1);
    @(negedge clk);
    set_ready(b, 1'b0);
    checkOutput("ovalid_after_take", 140'(get_ovalid(b)), 140'd0);
    checkOutput("iready_after_take", 140'(get_iready(b)), 140'd1);
    if (with_next) begin
      acc_cyc = cyc + 1;
      sbq.push_back(model(nxt, !b));
      @(negedge clk);
      drive(b, 1'b0, ~nxt);
      checkOutput("second_accepted", 140'(get_iready(b)), 140'd0);
    end
  endtask

  task automatic checkCleared(input bit b, input string tag);
    res_t o;
    o = sample(b);
    checkOutput({tag, "_ovalid"}, 140'(get_ovalid(b)), 140'd0);
    checkOutput({tag, "_iready"}, 140'(get_iready(b)), 140'd1);
    checkOutput({tag, "_fields"}, 140'({o.sign, o.ex, o.flags}), 140'd0);
    checkOutput({tag, "_sig"}, o.sig, 140'd0);
  endtask

  task automatic runOne(input bit b, input logic [127:0] x);
    applyStimulus(b, x);
    checkResult(b, 0, 1'b0, 128'd0);
  endtask

  initial begin
    logic [127:0] x;

    // Reference decode table: invert the encoder, then map the non-canonical
    // patterns (p,q ignored) onto their canonical twins.
    for (int p = 0; p < 1024; p++) dec_tab[p] = -1;
    for (int v = 0; v < 1000; v++) dec_tab[dpd_enc(v)] = v;
    for (int p = 0; p < 1024; p++)
      if (dec_tab[p] < 0) dec_tab[p] = dec_tab[p & 10'h0FF];

    ifa.i_valid = 1'b0; ifa.i = '0; ifa.o_ready = 1'b0;
    ifb.i_valid = 1'b0; ifb.i = '0; ifb.o_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkCleared(1'b0, "reset_a");
    checkCleared(1'b1, "reset_b");
    rst_n = 1'b1;

    $display("[TB] normalizing instance: directed operands");
    runOne(1'b0, ONE_E0);
    runOne(1'b0, 128'h00FF);
    runOne(1'b0, 128'h03FF);
    runOne(1'b0, {16'hF800, 112'd0});
    runOne(1'b0, {16'h7C00, 112'd0});
    runOne(1'b0, {16'h7E00, 112'd0});
    runOne(1'b0, {16'h7C00, 112'h123});
    runOne(1'b0, 128'd0);
    runOne(1'b0, {1'b0, 5'b11001, 12'h0AB, 110'h2_3456_789A_BCDE});
    runOne(1'b1 == 1'b0 ? 1'b1 : 1'b0, {1'b1, 5'b00000, 12'h005, 110'h000_0000_0000_1234});

    $display("[TB] backpressure with a second operand waiting");
    applyStimulus(1'b0, {1'b0, 5'b01010, 12'h123, 110'h0_0000_0000_0000_03A7});
    checkResult(1'b0, 5, 1'b1, {1'b1, 5'b10001, 12'h456, 110'h1_2345_6789_ABCD});
    checkResult(1'b0, 0, 1'b0, 128'd0);

    $display("[TB] reset in the middle of decoding");
    applyStimulus(1'b0, ONE_E0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkCleared(1'b0, "midreset");
    void'(sbq.pop_back());
    runOne(1'b0, ONE_E0);

    $display("[TB] pseudo-random operands");
    for (int n = 0; n < 4; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      runOne(1'b0, x);
    end

    $display("[TB] non-normalizing instance");
    runOne(1'b1, ONE_E0);
    runOne(1'b1, 128'd0);
    runOne(1'b1, {1'b0, 5'b00000, 12'h100, 110'h0_0000_0000_0000_0001});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
